// File: rtl/seq_1011_pkg.sv
// seq_1011_pkg: shared sync marker, stuffing trigger and FSM state type for the 1011 link
package seq_1011_pkg;

    localparam int SYNC_W = 4;
    localparam logic [SYNC_W-1:0] SYNC_PAT = 4'b1011;
    localparam int SYNC_CW = $clog2(SYNC_W);

    // A data bit completing the marker prefix 101 must be followed by a 0
    localparam logic [2:0] STUFF_TRIG = SYNC_PAT[SYNC_W-1 -: 3];

    typedef enum logic [2:0] {IDLE, SYNC, DATA, STUFF, GAP} state_t;

    function automatic logic sync_bit(input logic [SYNC_CW-1:0] idx);
        return SYNC_PAT[SYNC_CW'(SYNC_W - 1) - idx];
    endfunction

endpackage

// File: rtl/seq_stuff_ctl.sv
// seq_stuff_ctl: line-bit history and zero-stuff request for the 1011 frame transmitter
module seq_stuff_ctl (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic shift,
    input  logic cur_bit,
    output logic stuff_req
);
    import seq_1011_pkg::*;

    logic [2:0] hist;
    logic       unused_hist;

    assign unused_hist = hist[2];
    assign stuff_req   = {hist[1:0], cur_bit} == STUFF_TRIG;

    // Last three line bits, restarted on every accepted word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            hist <= '0;
        else if (clr)
            hist <= '0;
        else if (shift)
            hist <= {hist[1:0], cur_bit};
    end

endmodule

// File: rtl/seq_gen_1011.sv
// seq_gen_1011: serial transmitter sending 1011 sync plus zero-stuffed MSB-first payload
module seq_gen_1011 #(
    parameter int DATA_W = 8,
    parameter int GAP    = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              sout,
    output logic              sout_en,
    output logic              busy,
    output logic              frame_done
);
    import seq_1011_pkg::*;

    localparam int BW = $clog2(DATA_W + 1);
    localparam int GW = $clog2(GAP + 2);

    state_t             state, state_n;
    logic [SYNC_CW-1:0] sync_cnt, sync_cnt_n;
    logic [BW-1:0]      bit_cnt, bit_cnt_n;
    logic [GW-1:0]      gap_cnt, gap_cnt_n;
    logic [DATA_W-1:0]  sh, sh_n;
    logic               accept, on_line, cur_bit, stuff_req, frame_end, line_n, bit_n;

    assign in_ready = (state == IDLE) && rst_n;
    assign accept   = in_valid && in_ready;
    assign on_line  = state inside {SYNC, DATA, STUFF};
    assign cur_bit  = (state == SYNC) ? sync_bit(sync_cnt) :
                      (state == DATA) ? sh[DATA_W-1] : 1'b0;

    seq_stuff_ctl u_stuff (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (accept),
        .shift     (on_line),
        .cur_bit   (cur_bit),
        .stuff_req (stuff_req)
    );

    // Frame sequencing: bit_cnt counts payload bits already sent so STUFF knows if the word is done
    always_comb begin
        state_n    = state;
        sync_cnt_n = sync_cnt;
        bit_cnt_n  = bit_cnt;
        gap_cnt_n  = gap_cnt;
        sh_n       = sh;
        frame_end  = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_n    = SYNC;
                    sync_cnt_n = '0;
                    sh_n       = in_data;
                end
            end
            SYNC: begin
                if (sync_cnt == SYNC_CW'(SYNC_W - 1)) begin
                    state_n   = DATA;
                    bit_cnt_n = '0;
                end else begin
                    sync_cnt_n = sync_cnt + 1'b1;
                end
            end
            DATA: begin
                sh_n      = sh << 1;
                bit_cnt_n = bit_cnt + 1'b1;
                if (stuff_req)
                    state_n = STUFF;
                else if (bit_cnt == BW'(DATA_W - 1))
                    frame_end = 1'b1;
            end
            STUFF: begin
                if (bit_cnt == BW'(DATA_W))
                    frame_end = 1'b1;
                else
                    state_n = DATA;
            end
            seq_1011_pkg::GAP: begin
                gap_cnt_n = gap_cnt + 1'b1;
                if (gap_cnt == GW'(GAP - 1))
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        if (frame_end) begin
            state_n   = (GAP > 0) ? seq_1011_pkg::GAP : IDLE;
            gap_cnt_n = '0;
        end
    end

    // Line value for the coming cycle, taken from the next state so outputs can be registered
    always_comb begin
        line_n = state_n inside {SYNC, DATA, STUFF};
        bit_n  = (state_n == SYNC) ? sync_bit(sync_cnt_n) :
                 (state_n == DATA) ? sh_n[DATA_W-1] : 1'b0;
    end

    // State, counters and registered outputs; reset drops the line immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            sync_cnt   <= '0;
            bit_cnt    <= '0;
            gap_cnt    <= '0;
            sh         <= '0;
            sout       <= 1'b0;
            sout_en    <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_n;
            sync_cnt   <= sync_cnt_n;
            bit_cnt    <= bit_cnt_n;
            gap_cnt    <= gap_cnt_n;
            sh         <= sh_n;
            sout       <= line_n & bit_n;
            sout_en    <= line_n;
            busy       <= state_n != IDLE;
            frame_done <= frame_end;
        end
    end

endmodule

// File: tb/tb_seq_gen_1011.sv
// tb_seq_gen_1011: randomized and directed checks of the 1011 frame transmitter
module tb_seq_gen_1011;

    localparam int GAP_M = 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = '0;
    logic       in_ready, sout, sout_en, busy, frame_done;
    logic       v0 = 1'b0;
    logic [7:0] d0 = '0;
    logic       rdy0, so0, en0, busy0, fd0;

    int n_checks = 0;
    int n_fail = 0;

    logic [7:0]  dw [4] = '{8'hA5, 8'h00, 8'hFF, 8'h2D};
    logic [15:0] fw [4] = '{16'b10111010001010, 16'h0B00, 16'h0BFF, 16'b10110010101001};
    int          fl [4] = '{14, 12, 12, 14};

    seq_gen_1011 #(.DATA_W(8), .GAP(GAP_M)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .sout(sout), .sout_en(sout_en), .busy(busy), .frame_done(frame_done)
    );

    seq_gen_1011 #(.DATA_W(8), .GAP(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(v0), .in_data(d0),
        .in_ready(rdy0), .sout(so0), .sout_en(en0), .busy(busy0), .frame_done(fd0)
    );

    always #5 clk = ~clk;

    // Reference frame: marker, then payload MSB first, a 0 inserted whenever the line ends in 101
    function automatic void build_frame(input logic [7:0] d, output logic [63:0] val, output int len);
        bit q[$];
        q = '{1, 0, 1, 1};
        for (int i = 7; i >= 0; i--) begin
            q.push_back(d[i]);
            if (q[q.size()-3] == 1 && q[q.size()-2] == 0 && q[q.size()-1] == 1)
                q.push_back(0);
        end
        val = '0;
        foreach (q[j]) val = {val[62:0], q[j]};
        len = q.size();
    endfunction

    task automatic xmit(input logic [7:0] d, input bit noise, output logic [63:0] obs, output int len,
                        output int done_at, output int done_cnt, output int busy_len,
                        output int marks, output bit line_bad);
        logic [3:0] w;
        obs = '0; len = 0; done_at = -1; done_cnt = 0; busy_len = 0; marks = 0; line_bad = 0; w = '0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        @(negedge clk);
        in_valid = noise;
        in_data  = 8'($urandom);
        for (int c = 0; c < 80 && busy; c++) begin
            busy_len++;
            if (sout_en) begin
                obs = {obs[62:0], sout};
                len++;
                w = {w[2:0], sout};
                if (w == 4'b1011) marks++;
            end else if (sout) begin
                line_bad = 1;
            end
            if (frame_done) begin
                if (done_cnt == 0) done_at = c;
                done_cnt++;
            end
            if (in_ready) line_bad = 1;
            if (noise) begin
                in_valid = 1'($urandom);
                in_data  = 8'($urandom);
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({in_ready, sout, sout_en, busy, frame_done} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_hold: {rdy,sout,en,busy,done}=%b want 00000",
                     {in_ready, sout, sout_en, busy, frame_done});
        end
        rst_n = 1'b1;
        #1;
        n_checks++;
        if ({in_ready, sout, sout_en, busy, frame_done} !== 5'b10000) begin
            n_fail++;
            $display("FAIL reset_release: {rdy,sout,en,busy,done}=%b want 10000",
                     {in_ready, sout, sout_en, busy, frame_done});
        end
    endtask

    task automatic test_directed();
        logic [63:0] obs;
        int len, done_at, done_cnt, busy_len, marks;
        bit bad;
        for (int i = 0; i < 4; i++) begin
            xmit(dw[i], 0, obs, len, done_at, done_cnt, busy_len, marks, bad);
            n_checks += 5;
            if (obs !== 64'(fw[i]) || len !== fl[i]) begin
                n_fail++;
                $display("FAIL dir_bits[%h]: got %0d bits %b want %0d bits %b", dw[i], len, obs[15:0], fl[i], fw[i]);
            end
            if (done_at !== fl[i] || done_cnt !== 1) begin
                n_fail++;
                $display("FAIL dir_done[%h]: at %0d count %0d want at %0d count 1", dw[i], done_at, done_cnt, fl[i]);
            end
            if (busy_len !== fl[i] + GAP_M) begin
                n_fail++;
                $display("FAIL dir_busy[%h]: %0d cycles want %0d", dw[i], busy_len, fl[i] + GAP_M);
            end
            if (marks !== 1) begin
                n_fail++;
                $display("FAIL dir_marker[%h]: 1011 seen %0d times in frame want 1", dw[i], marks);
            end
            if (bad !== 0) begin
                n_fail++;
                $display("FAIL dir_line[%h]: line/in_ready violation got 1 want 0", dw[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [63:0] obs, mval;
        int len, mlen, done_at, done_cnt, busy_len, marks;
        bit bad, quiet;
        logic [7:0] d;
        for (int i = 0; i < 16; i++) begin
            d = 8'($urandom);
            build_frame(d, mval, mlen);
            xmit(d, 1, obs, len, done_at, done_cnt, busy_len, marks, bad);
            quiet = 1;
            repeat (3) begin
                @(negedge clk);
                if (sout_en || busy || sout) quiet = 0;
            end
            n_checks += 6;
            if (obs !== mval || len !== mlen) begin
                n_fail++;
                $display("FAIL rnd_bits[%h]: got %0d bits %h want %0d bits %h", d, len, obs, mlen, mval);
            end
            if (done_at !== mlen || done_cnt !== 1) begin
                n_fail++;
                $display("FAIL rnd_done[%h]: at %0d count %0d want at %0d count 1", d, done_at, done_cnt, mlen);
            end
            if (busy_len !== mlen + GAP_M) begin
                n_fail++;
                $display("FAIL rnd_busy[%h]: %0d cycles want %0d", d, busy_len, mlen + GAP_M);
            end
            if (marks !== 1) begin
                n_fail++;
                $display("FAIL rnd_marker[%h]: 1011 seen %0d times want 1", d, marks);
            end
            if (bad !== 0) begin
                n_fail++;
                $display("FAIL rnd_line[%h]: line/in_ready violation got 1 want 0", d);
            end
            if (quiet !== 1) begin
                n_fail++;
                $display("FAIL rnd_not_queued[%h]: activity after frame got 1 want 0", d);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] va, vb;
        int la, lb, dets, done_cnt, diffs, p0, p1;
        bit s [46];
        bit e [46];
        bit drop;
        logic [3:0] w;
        build_frame(8'hA5, va, la);
        build_frame(8'h2D, vb, lb);
        foreach (e[j]) e[j] = 0;
        for (int j = 0; j < la; j++) e[j] = va[la-1-j];
        for (int j = 0; j < lb; j++) e[la+1+j] = vb[lb-1-j];
        @(negedge clk);
        v0 = 1'b1;
        d0 = 8'hA5;
        @(negedge clk);
        d0 = 8'h2D;
        drop = 0; w = '0; dets = 0; done_cnt = 0; p0 = -1; p1 = -1; diffs = 0;
        for (int c = 0; c < 46; c++) begin
            s[c] = so0;
            if (fd0) done_cnt++;
            w = {w[2:0], so0};
            if (w == 4'b1011) begin
                if (dets == 0) p0 = c; else p1 = c;
                dets++;
            end
            if (drop) v0 = 1'b0;
            drop = rdy0 && v0;
            @(negedge clk);
        end
        v0 = 1'b0;
        foreach (s[j]) if (s[j] != e[j]) diffs++;
        n_checks += 3;
        if (diffs !== 0) begin
            n_fail++;
            $display("FAIL b2b_stream: %0d line bits differ want 0", diffs);
        end
        if (dets !== 2 || p0 !== 3 || p1 !== la + 4) begin
            n_fail++;
            $display("FAIL b2b_det: %0d events at %0d,%0d want 2 at 3,%0d", dets, p0, p1, la + 4);
        end
        if (done_cnt !== 2) begin
            n_fail++;
            $display("FAIL b2b_done: %0d pulses want 2", done_cnt);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [63:0] obs;
        int len, done_at, done_cnt, busy_len, marks;
        bit bad, stray;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 8'hFF;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (6) @(negedge clk);
        n_checks++;
        if ({busy, sout_en, sout} !== 3'b111) begin
            n_fail++;
            $display("FAIL mid_inflight: {busy,en,sout}=%b want 111", {busy, sout_en, sout});
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({in_ready, sout, sout_en, busy, frame_done} !== 5'b0) begin
            n_fail++;
            $display("FAIL mid_async: {rdy,sout,en,busy,done}=%b want 00000",
                     {in_ready, sout, sout_en, busy, frame_done});
        end
        @(negedge clk);
        rst_n = 1'b1;
        stray = 0;
        repeat (3) begin
            @(negedge clk);
            if (frame_done || busy || sout_en) stray = 1;
        end
        n_checks++;
        if (stray !== 0) begin
            n_fail++;
            $display("FAIL mid_no_done: activity after abandoned frame got 1 want 0");
        end
        xmit(8'hA5, 0, obs, len, done_at, done_cnt, busy_len, marks, bad);
        n_checks++;
        if (obs !== 64'(fw[0]) || len !== 14 || done_at !== 14 || bad !== 0) begin
            n_fail++;
            $display("FAIL mid_recover: %0d bits %b done_at %0d bad %0d want 14 bits %b done_at 14 bad 0",
                     len, obs[15:0], done_at, bad, fw[0]);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
